// File: rtl/system_define.sv
// Shared constants and FSM state encoding for the vertical result collector.
//   NUM_CORE_V : number of vertical cores feeding the collector
//   DATA_W_V   : result word width per core
//   ID_W_V     : width of a binary core index
package system_define;

  localparam int NUM_CORE_V = 10;
  localparam int DATA_W_V   = 16;
  localparam int ID_W_V     = $clog2(NUM_CORE_V);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SEND  = 2'd2,
    DROP  = 2'd3
  } collector_state_e;

endpackage

// File: rtl/arbiter_basic_vh.sv
// Fixed-priority arbiter: the highest-index requester wins.
// Ports:
//   i_req   [NUM_CORE_V-1:0] : per-core request vector
//   o_grant [NUM_CORE_V-1:0] : one-hot grant (all zero when nothing requests)
module arbiter_basic_vh
  import system_define::*;
(
  input  logic [NUM_CORE_V-1:0] i_req,
  output logic [NUM_CORE_V-1:0] o_grant
);

  logic w_found;

  // Scan from the top index down; the first request seen takes the grant.
  always_comb begin
    o_grant = {NUM_CORE_V{1'b0}};
    w_found = 1'b0;
    for (int i = NUM_CORE_V - 1; i >= 0; i--) begin
      if (i_req[i] && !w_found) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end else begin
        o_grant[i] = o_grant[i];
      end
    end
  end

endmodule

// File: rtl/result_collector_vh.sv
// Collects result words from NUM_CORE_V cores one at a time and forwards them
// over a valid/ready output with the source core index.
// Ports:
//   clk, rst_n   : clock (rising edge) and asynchronous active-low reset
//   core_req     : per-core level request, held with its data until ack
//   core_data    : packed per-core result words, slice i = core i
//   core_ack     : one-hot single-cycle acknowledge to the served core
//   out_valid    : collected word available
//   out_ready    : downstream accepts the word
//   out_data     : collected word
//   out_core_id  : binary index of the source core
//   xfer_count   : completed output handshakes, wrapping 16-bit
module result_collector_vh
  import system_define::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CORE_V-1:0]          core_req,
  input  logic [NUM_CORE_V*DATA_W_V-1:0] core_data,
  output logic [NUM_CORE_V-1:0]          core_ack,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W_V-1:0]            out_data,
  output logic [ID_W_V-1:0]              out_core_id,
  output logic [15:0]                    xfer_count
);

  collector_state_e        r_state;
  collector_state_e        w_next_state;
  logic [NUM_CORE_V-1:0]   w_grant_oh;
  logic [NUM_CORE_V-1:0]   r_grant;
  logic [DATA_W_V-1:0]     w_sel_data;
  logic                    w_handshake;
  logic                    w_granted_req;
  logic                    r_out_valid;
  logic [DATA_W_V-1:0]     r_out_data;
  logic [ID_W_V-1:0]       r_out_core_id;
  logic [NUM_CORE_V-1:0]   r_core_ack;
  logic [15:0]             r_xfer_count;

  function automatic logic [ID_W_V-1:0] onehot_to_bin(input logic [NUM_CORE_V-1:0] oh);
    logic [ID_W_V-1:0] idx;
    idx = {ID_W_V{1'b0}};
    for (int i = 0; i < NUM_CORE_V; i++) begin
      if (oh[i]) begin
        idx = idx | ID_W_V'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  arbiter_basic_vh u_arbiter (
    .i_req   (core_req),
    .o_grant (w_grant_oh)
  );

  assign w_handshake   = r_out_valid & out_ready;
  assign w_granted_req = |(core_req & r_grant);

  // AND-OR data mux driven by the registered one-hot grant.
  always_comb begin
    w_sel_data = {DATA_W_V{1'b0}};
    for (int i = 0; i < NUM_CORE_V; i++) begin
      if (r_grant[i]) begin
        w_sel_data = w_sel_data | core_data[i*DATA_W_V +: DATA_W_V];
      end else begin
        w_sel_data = w_sel_data;
      end
    end
  end

  // Next-state logic of the collection FSM.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (|core_req) w_next_state = LATCH;
        else           w_next_state = IDLE;
      end
      LATCH: w_next_state = SEND;
      SEND: begin
        if (w_handshake) w_next_state = DROP;
        else             w_next_state = SEND;
      end
      DROP: begin
        // Wait for the served core to withdraw so it is not served twice.
        if (w_granted_req) w_next_state = DROP;
        else               w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Grant is loaded only when leaving IDLE, so later requests cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= {NUM_CORE_V{1'b0}};
    end else if ((r_state == IDLE) && (|core_req)) begin
      r_grant <= w_grant_oh;
    end else begin
      r_grant <= r_grant;
    end
  end

  // Output word and index are captured once in LATCH and then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data    <= {DATA_W_V{1'b0}};
      r_out_core_id <= {ID_W_V{1'b0}};
    end else if (r_state == LATCH) begin
      r_out_data    <= w_sel_data;
      r_out_core_id <= onehot_to_bin(r_grant);
    end else begin
      r_out_data    <= r_out_data;
      r_out_core_id <= r_out_core_id;
    end
  end

  // out_valid rises on entry to SEND and falls with the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (r_state == LATCH) begin
      r_out_valid <= 1'b1;
    end else if (w_handshake) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Acknowledge is a one-cycle copy of the one-hot grant after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_ack <= {NUM_CORE_V{1'b0}};
    end else if (w_handshake) begin
      r_core_ack <= r_grant;
    end else begin
      r_core_ack <= {NUM_CORE_V{1'b0}};
    end
  end

  // Handshake counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_count <= 16'd0;
    end else if (w_handshake) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end else begin
      r_xfer_count <= r_xfer_count;
    end
  end

  assign core_ack    = r_core_ack;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_core_id = r_out_core_id;
  assign xfer_count  = r_xfer_count;

endmodule

// File: tb/tb_result_collector_vh.sv
module tb_result_collector_vh;
  import system_define::*;

  logic                           clk;
  logic                           rst_n;
  logic [NUM_CORE_V-1:0]          core_req;
  logic [NUM_CORE_V*DATA_W_V-1:0] core_data;
  logic [NUM_CORE_V-1:0]          core_ack;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_W_V-1:0]            out_data;
  logic [ID_W_V-1:0]              out_core_id;
  logic [15:0]                    xfer_count;

  int          checks;
  int          errors;
  logic [15:0] exp_count;
  logic [15:0] exp_data [NUM_CORE_V];

  result_collector_vh dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_req    (core_req),
    .core_data   (core_data),
    .core_ack    (core_ack),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_core_id (out_core_id),
    .xfer_count  (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the highest-numbered pending core is served next.
  function automatic int highest(input logic [NUM_CORE_V-1:0] mask);
    for (int i = NUM_CORE_V - 1; i >= 0; i--) begin
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic raise(input int id, input logic [15:0] d);
    exp_data[id] = d;
    core_data[id*DATA_W_V +: DATA_W_V] = d;
    core_req[id] = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'd2);
  endtask

  // Completes a transfer already showing out_valid; core drops request on ack
  // (optionally after holding it for 'hold' extra cycles).
  task automatic finish(input string tag, input int id, input logic [15:0] d,
                        input int stall, input int hold);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_id"}, 32'(out_core_id), 32'(id));
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_stall_data"}, 32'(out_data), 32'(d));
      chk({tag, "_stall_id"}, 32'(out_core_id), 32'(id));
      chk({tag, "_stall_noack"}, 32'(core_ack), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    chk({tag, "_ack"}, 32'(core_ack), 32'd1 << id);
    chk({tag, "_valid_low"}, 32'(out_valid), 32'd0);
    chk({tag, "_count"}, 32'(xfer_count), 32'(exp_count));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_hold_ack"}, 32'(core_ack), 32'd0);
    end
    core_req[id] = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_pulse"}, 32'(core_ack), 32'd0);
  endtask

  initial begin
    logic [NUM_CORE_V-1:0] mask;
    int id;
    checks    = 0;
    errors    = 0;
    exp_count = 16'd0;
    rst_n     = 1'b0;
    core_req  = '0;
    core_data = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_CORE_V; i++) exp_data[i] = 16'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ack", 32'(core_ack), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_id", 32'(out_core_id), 32'd0);
    chk("rst_count", 32'(xfer_count), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Single request from core 2
    raise(2, 16'hABCD);
    wait_valid("single");
    finish("single", 2, 16'hABCD, 0, 0);

    // Simultaneous requests 0x209 served 9, 3, 0
    raise(9, 16'($urandom));
    raise(3, 16'($urandom));
    raise(0, 16'($urandom));
    mask = core_req;
    while (mask != '0) begin
      id = highest(mask);
      wait_valid("multi");
      finish("multi", id, exp_data[id], 0, 0);
      mask[id] = 1'b0;
    end
    chk("multi_total", 32'(xfer_count), 32'd4);

    // Backpressure for 5 cycles, request held in DROP for 4 cycles
    raise(7, 16'($urandom));
    wait_valid("bp");
    finish("bp", 7, exp_data[7], 5, 4);

    // Late arrival of core 8 while core 5 is in SEND; core 5 data changes too
    raise(5, 16'($urandom));
    wait_valid("late5");
    core_req[8] = 1'b1;
    exp_data[8] = 16'($urandom);
    core_data[8*DATA_W_V +: DATA_W_V] = exp_data[8];
    core_data[5*DATA_W_V +: DATA_W_V] = ~exp_data[5];
    finish("late5", 5, exp_data[5], 2, 0);
    wait_valid("late8");
    finish("late8", 8, exp_data[8], 0, 0);

    // Granted core drops its request during SEND
    raise(1, 16'($urandom));
    wait_valid("dropsend");
    core_req[1] = 1'b0;
    finish("dropsend", 1, exp_data[1], 1, 0);

    // Reset in SEND abandons the transfer; pending request served again
    raise(6, 16'($urandom));
    wait_valid("rstsend");
    rst_n = 1'b0;
    #1;
    chk("rstsend_valid", 32'(out_valid), 32'd0);
    chk("rstsend_ack", 32'(core_ack), 32'd0);
    chk("rstsend_count", 32'(xfer_count), 32'd0);
    exp_count = 16'd0;
    @(negedge clk);
    chk("rstsend_ack2", 32'(core_ack), 32'd0);
    rst_n = 1'b1;
    wait_valid("rerun");
    finish("rerun", 6, exp_data[6], 0, 0);

    // Randomized rounds of simultaneous requests
    for (int r = 0; r < 8; r++) begin
      mask = NUM_CORE_V'($urandom_range(1, (1 << NUM_CORE_V) - 1));
      for (int i = 0; i < NUM_CORE_V; i++) begin
        if (mask[i]) raise(i, 16'($urandom));
      end
      while (mask != '0) begin
        id = highest(mask);
        wait_valid("rand");
        finish("rand", id, exp_data[id], $urandom_range(0, 2), $urandom_range(0, 1));
        mask[id] = 1'b0;
      end
    end

    // Counter wrap: preload to 0xFFFF, one more transfer gives 0
    force dut.r_xfer_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_xfer_count;
    exp_count = 16'hFFFF;
    @(negedge clk);
    chk("wrap_preload", 32'(xfer_count), 32'h0000FFFF);
    raise(4, 16'($urandom));
    wait_valid("wrap");
    finish("wrap", 4, exp_data[4], 0, 0);
    chk("wrap_zero", 32'(xfer_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
